mult_axi4_lite_slave: RTL

//  AXI4-Lite responder for the multiplication IP; the S00_AXI end that the master BFM drives.
//  - Register file: four plain R/W words, control/status, 64-bit result.
//  - Sequential 32x32 unsigned shift-add multiplier, 1 bit per cycle.
//  - Completion interrupt.

---
 rtl/mult_axi4_lite_slave.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mult_axi4_lite_slave.sv
// AXI4-Lite register slave around a 32x32 unsigned shift-add multiplier (1 bit per cycle).
// Optional build macro MULT_AXI_SLVERR_EN: SLVERR on writes to 0x14..0x1C and reads of 0x1C.
module mult_axi4_lite_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            mult_done_irq
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] IDX_CTRL    = 3'd4;

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic [31:0] regs_q [4];
   logic [31:0] regs_d [4];
   logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [4:0]  count_q, count_d;
   logic [63:0] mcand_q, mcand_d, acc_q, acc_d, res_q, res_d;
   logic [31:0] mplier_q, mplier_d;
   logic [63:0] acc_sum;
   logic [2:0]  wr_idx, rd_idx;
   logic        wr_en, start_req, clr_req;
   logic        unused_ok;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
      logic [31:0] out_w;
      out_w = old_w;
      for (int i = 0; i < 4; i++)
         if (strb[i]) out_w[8*i +: 8] = new_w[8*i +: 8];
      return out_w;
   endfunction

   // Address/data are sampled in W_ACK: the master must still hold them since ready is not yet seen.
   assign wr_en     = (w_state_q == W_ACK);
   assign wr_idx    = S_AXI_AWADDR[4:2];
   assign rd_idx    = S_AXI_ARADDR[4:2];
   assign start_req = wr_en && (wr_idx == IDX_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
   assign clr_req   = wr_en && (wr_idx == IDX_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
   assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        S_AXI_WDATA[1], S_AXI_WDATA[31:3]};

   // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
   always_comb begin
      w_state_d = w_state_q;
      regs_d    = regs_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = W_ACK;
         W_ACK:   w_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      if (wr_en) begin
         if (wr_idx < IDX_CTRL)
            regs_d[wr_idx[1:0]] = merge_bytes(regs_q[wr_idx[1:0]], S_AXI_WDATA[31:0], S_AXI_WSTRB[3:0]);
`ifdef MULT_AXI_SLVERR_EN
         bresp_d = (wr_idx > IDX_CTRL) ? RESP_SLVERR : RESP_OKAY;
`else
         bresp_d = RESP_OKAY;
`endif
      end
   end

   // Clear is applied before completion so a same-cycle done set wins; start is ignored while busy.
   always_comb begin
      busy_d   = busy_q;
      done_d   = done_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      res_d    = res_q;
      if (clr_req) done_d = 1'b0;
      if (busy_q) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 5'd1;
         if (count_q == 5'd31) begin
            res_d  = acc_sum;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end else if (start_req) begin
         mcand_d  = {32'd0, regs_q[0]};
         mplier_d = regs_q[1];
         acc_d    = 64'd0;
         count_d  = 5'd0;
         busy_d   = 1'b1;
         done_d   = 1'b0;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: if (S_AXI_ARVALID) r_state_d = R_ADDR;
         R_ADDR: begin
            r_state_d = R_DATA;
            rresp_d   = RESP_OKAY;
            case (rd_idx)
               3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[rd_idx[1:0]];
               3'd4:    rdata_d = {29'd0, done_q, busy_q, 1'b0};
               3'd5:    rdata_d = res_q[31:0];
               3'd6:    rdata_d = res_q[63:32];
               default: begin
                  rdata_d = 32'd0;
`ifdef MULT_AXI_SLVERR_EN
                  rresp_d = RESP_SLVERR;
`endif
               end
            endcase
         end
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // NOTE: the register file is small and software-visible, so it is reset like any other state.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         for (int i = 0; i < 4; i++) regs_q[i] <= 32'd0;
         bresp_q   <= RESP_OKAY;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= 5'd0;
         mcand_q   <= 64'd0;
         mplier_q  <= 32'd0;
         acc_q     <= 64'd0;
         res_q     <= 64'd0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its _d signal.
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         regs_q    <= regs_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         count_q   <= count_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
      end
   end

   assign S_AXI_AWREADY = (w_state_q == W_ACK);
   assign S_AXI_WREADY  = (w_state_q == W_ACK);
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = (r_state_q == R_ADDR);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign mult_done_irq = done_q;

endmodule
